// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: hands a nonce range out to external hash cores and
// reports the first nonce whose hash falls below the target.
module nonce_dispatcher #(
    parameter int CORE_COUNT = 4,
    parameter int NONCE_W    = 32,
    parameter int HASH_W     = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_load,
    input  logic [NONCE_W-1:0]             job_nonce_start,
    input  logic [NONCE_W-1:0]             job_nonce_end,
    input  logic [HASH_W-1:0]              job_target,
    input  logic                           abort,
    output logic [CORE_COUNT-1:0]          core_start,
    output logic [CORE_COUNT*NONCE_W-1:0]  core_nonce,
    input  logic [CORE_COUNT-1:0]          core_ready,
    input  logic [CORE_COUNT*HASH_W-1:0]   core_hash,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [NONCE_W-1:0]             res_nonce,
    output logic                           busy,
    output logic                           exhausted,
    output logic [31:0]                    hash_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    localparam logic [NONCE_W:0] NN_ONE = {{NONCE_W{1'b0}}, 1'b1};

    state_t                          state_q, state_d;
    logic [CORE_COUNT-1:0]           busy_q, busy_d, start_d, acc;
    logic [NONCE_W:0]                next_q, next_d, nn;
    logic [NONCE_W-1:0]              end_q, end_d, res_nonce_d, win_nonce;
    logic [HASH_W-1:0]               target_q, target_d;
    logic                            drain_report_q, drain_report_d;
    logic                            exhausted_d, hit;
    logic [31:0]                     hash_count_d;
    logic [CORE_COUNT*NONCE_W-1:0]   core_nonce_d;
    logic [5:0]                      n_acc;
    logic [32:0]                     sum;

    assign res_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);

    always_comb begin
        acc       = core_ready & busy_q;
        hit       = 1'b0;
        win_nonce = '0;
        n_acc     = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            n_acc = n_acc + {5'd0, acc[i]};
            if (acc[i] && !hit &&
                core_hash[i*HASH_W +: HASH_W] < target_q) begin
                hit       = 1'b1;
                win_nonce = core_nonce[i*NONCE_W +: NONCE_W];
            end
        end
        sum = {1'b0, hash_count} + {27'd0, n_acc};
    end

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q & ~acc;
        start_d        = '0;
        next_d         = next_q;
        end_d          = end_q;
        target_d       = target_q;
        drain_report_d = drain_report_q;
        exhausted_d    = exhausted;
        res_nonce_d    = res_nonce;
        core_nonce_d   = core_nonce;
        hash_count_d   = sum[32] ? '1 : sum[31:0];
        nn             = next_q;
        unique case (state_q)
            IDLE: begin
                if (job_load) begin
                    next_d       = {1'b0, job_nonce_start};
                    end_d        = job_nonce_end;
                    target_d     = job_target;
                    exhausted_d  = 1'b0;
                    hash_count_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (hit) begin
                    res_nonce_d    = win_nonce;
                    drain_report_d = 1'b1;
                    state_d        = DRAIN;
                end else if (abort) begin
                    drain_report_d = 1'b0;
                    state_d        = DRAIN;
                end else if (next_q > {1'b0, end_q} && busy_q == '0) begin
                    exhausted_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // a core returning this edge waits one cycle before reuse
                    for (int i = 0; i < CORE_COUNT; i++) begin
                        if (!busy_q[i] && !core_ready[i] &&
                            nn <= {1'b0, end_q}) begin
                            start_d[i] = 1'b1;
                            busy_d[i]  = 1'b1;
                            core_nonce_d[i*NONCE_W +: NONCE_W] =
                                nn[NONCE_W-1:0];
                            nn = nn + NN_ONE;
                        end
                    end
                    next_d = nn;
                end
            end
            DRAIN: begin
                if (busy_q == '0)
                    state_d = drain_report_q ? REPORT : IDLE;
            end
            REPORT: begin
                if (res_ready)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            busy_q         <= '0;
            core_start     <= '0;
            next_q         <= '0;
            end_q          <= '0;
            target_q       <= '0;
            drain_report_q <= 1'b0;
            exhausted      <= 1'b0;
            res_nonce      <= '0;
            core_nonce     <= '0;
            hash_count     <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            core_start     <= start_d;
            next_q         <= next_d;
            end_q          <= end_d;
            target_q       <= target_d;
            drain_report_q <= drain_report_d;
            exhausted      <= exhausted_d;
            res_nonce      <= res_nonce_d;
            core_nonce     <= core_nonce_d;
            hash_count     <= hash_count_d;
        end
    end

endmodule
